avalon_mtimer: RTL and testbench

RISC-V machine timer (mtime/mtimecmp) exposed as an Avalon-MM responder on the core's data bus. It is the target the load/store unit talks to when the core accesses the timer region. It keeps a free-running 64-bit mtime counter with a programmable prescaler, holds a 64-bit mtimecmp, and drives the machine timer interrupt to the core's CSR/trap logic.

---
 rtl/avalon_mtimer.sv | 158 +++++++++++++++
 tb/tb_avalon_mtimer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as an Avalon-MM responder on the core data bus.
// Free-running 64-bit mtime with prescaler, 64-bit mtimecmp, registered level interrupt.
module avalon_mtimer #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [3:0]        avs_byteenable,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              timer_irq
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESC    = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        enable_q, enable_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic        irq_q, irq_d;

  reg_e        offset;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [31:0] rdata_mux;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return merged;
  endfunction

  assign offset           = reg_e'(avs_address[4:2]);
  assign unused_addr_bits = ^{avs_address[ADDR_W-1:5], avs_address[1:0]};

  // A simultaneous read is dropped in favour of the write.
  assign wr_en = avs_write;
  assign rd_en = avs_read & ~avs_write;
  assign tick  = enable_q && (pcnt_q == PCNT_MAX);

  always_comb begin
    rdata_mux = '0;
    unique case (offset)
      REG_MTIME_LO: rdata_mux = mtime_q[31:0];
      REG_MTIME_HI: rdata_mux = hi_shadow_q;
      REG_CMP_LO:   rdata_mux = cmp_q[31:0];
      REG_CMP_HI:   rdata_mux = cmp_q[63:32];
      REG_CTRL:     rdata_mux = {31'd0, enable_q};
      REG_PRESC:    rdata_mux = {16'd0, pcnt_q};
      REG_RSVD6,
      REG_RSVD7:    rdata_mux = '0;
      default:      rdata_mux = '0;
    endcase
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    mtime_d     = mtime_q;
    cmp_d       = cmp_q;
    hi_shadow_d = hi_shadow_q;
    pcnt_d      = pcnt_q;
    enable_d    = enable_q;
    readdata_d  = readdata_q;
    rvalid_d    = rd_en;
    irq_d       = (mtime_q >= cmp_q);

    if (enable_q) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A write to either mtime half replaces the increment entirely, so no
    // carry reaches the other half in a tick cycle.
    if (wr_en) begin
      unique case (offset)
        REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 merge_bytes(mtime_q[31:0], avs_writedata, avs_byteenable)};
        REG_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], avs_writedata, avs_byteenable),
                                 mtime_q[31:0]};
        REG_CMP_LO:   cmp_d[31:0]  = merge_bytes(cmp_q[31:0], avs_writedata, avs_byteenable);
        REG_CMP_HI:   cmp_d[63:32] = merge_bytes(cmp_q[63:32], avs_writedata, avs_byteenable);
        REG_CTRL: begin
          if (avs_byteenable[0]) begin
            enable_d = avs_writedata[0];
          end
          pcnt_d = 16'd0;
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      readdata_d = rdata_mux;
      if (offset == REG_MTIME_LO) begin
        hi_shadow_d = mtime_q[63:32];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      cmp_q       <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_shadow_q <= 32'd0;
      pcnt_q      <= 16'd0;
      enable_q    <= 1'b1;
      readdata_q  <= 32'd0;
      rvalid_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      hi_shadow_q <= hi_shadow_d;
      pcnt_q      <= pcnt_d;
      enable_q    <= enable_d;
      readdata_q  <= readdata_d;
      rvalid_q    <= rvalid_d;
      irq_q       <= irq_d;
    end
  end

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign avs_waitrequest   = 1'b0;
  assign timer_irq         = irq_q;

endmodule

// File: tb/tb_avalon_mtimer.sv
// Directed bench for avalon_mtimer: one instance with PRESCALE=4 and one with
// PRESCALE=1 share the bus inputs; each check names the instance it compares.
module tb_avalon_mtimer;

  logic        clk;
  logic        rst;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_address;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;

  logic [31:0] rdata4, rdata1;
  logic        rdv4, rdv1;
  logic        wait4, wait1;
  logic        irq4, irq1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  off;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        exp_v;
    logic [31:0] exp4;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[17];

  avalon_mtimer #(.PRESCALE(4), .ADDR_W(32)) u_p4 (
    .clk               (clk),
    .rst               (rst),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (rdata4),
    .avs_readdatavalid (rdv4),
    .avs_waitrequest   (wait4),
    .timer_irq         (irq4)
  );

  avalon_mtimer #(.PRESCALE(1), .ADDR_W(32)) u_p1 (
    .clk               (clk),
    .rst               (rst),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (rdata1),
    .avs_readdatavalid (rdv1),
    .avs_waitrequest   (wait1),
    .timer_irq         (irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs seen then
  // belong to the cycle that just started.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic re, input logic [2:0] off,
                     input logic [3:0] b, input logic [31:0] d);
    avs_write      = we;
    avs_read       = re;
    avs_address    = 32'hABCD_1200 | {27'd0, off, 2'b11};
    avs_byteenable = b;
    avs_writedata  = d;
  endtask

  task automatic idle(input int n);
    bus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    repeat (n) step();
  endtask

  task automatic write_reg(input logic [2:0] off, input logic [3:0] b, input logic [31:0] d);
    bus(1'b1, 1'b0, off, b, d);
    step();
  endtask

  task automatic read_chk(input string name, input logic [2:0] off,
                          input logic [31:0] exp4, input logic [31:0] exp1);
    bus(1'b0, 1'b1, off, 4'h0, 32'h0);
    step();
    check({name, " rdv p4"}, 32'(rdv4), 32'd1);
    check({name, " rdv p1"}, 32'(rdv1), 32'd1);
    check({name, " data p4"}, rdata4, exp4);
    check({name, " data p1"}, rdata1, exp1);
  endtask

  // Leaves rst low with the first post-reset cycle (cycle 0) just starting.
  task automatic do_reset();
    bus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 4'h0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 4'h0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 4'h0, 32'h0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 4'h0, 32'h0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{1'b0, 1'b1, 3'd4, 4'h0, 32'h0,          1'b1, 32'h0000_0001, 32'h0000_0001};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 4'h0, 32'h0,          1'b1, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{1'b0, 1'b1, 3'd6, 4'h0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b0, 1'b1, 3'd7, 4'h0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 3'd2, 4'h5, 32'hAABB_CCDD,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 3'd2, 4'h0, 32'h0,          1'b1, 32'hFFBB_FFDD, 32'hFFBB_FFDD};
    vecs[10] = '{1'b1, 1'b1, 3'd3, 4'hF, 32'h1234_5678,  1'b0, 32'hFFBB_FFDD, 32'hFFBB_FFDD};
    vecs[11] = '{1'b0, 1'b1, 3'd3, 4'h0, 32'h0,          1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 4'h0, 32'h0,          1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[13] = '{1'b1, 1'b0, 3'd6, 4'hF, 32'hFFFF_FFFF,  1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[14] = '{1'b0, 1'b1, 3'd6, 4'h0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[15] = '{1'b1, 1'b0, 3'd4, 4'hF, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[16] = '{1'b0, 1'b1, 3'd4, 4'h0, 32'h0,          1'b1, 32'h0000_0001, 32'h0000_0001};

    // Reset state, full register map, byte enables, read+write collision.
    do_reset();
    check("reset irq p4", 32'(irq4), 32'd0);
    check("reset irq p1", 32'(irq1), 32'd0);
    check("reset rdv p4", 32'(rdv4), 32'd0);
    check("waitrequest p4", 32'(wait4), 32'd0);
    check("waitrequest p1", 32'(wait1), 32'd0);
    for (int i = 0; i < 17; i++) begin
      bus(vecs[i].we, vecs[i].re, vecs[i].off, vecs[i].be, vecs[i].wd);
      step();
      check($sformatf("vec%0d rdv p4", i), 32'(rdv4), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d rdv p1", i), 32'(rdv1), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d data p4", i), rdata4, vecs[i].exp4);
      check($sformatf("vec%0d data p1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d irq p1", i), 32'(irq1), 32'd0);
    end
    idle(1);

    // Prescaled counting, then disable holds mtime and clears pcnt.
    do_reset();
    write_reg(3'd4, 4'h1, 32'h1);
    idle(39);
    read_chk("count c40", 3'd0, 32'd9, 32'd40);
    read_chk("count c41", 3'd0, 32'd10, 32'd41);
    write_reg(3'd4, 4'h1, 32'h0);
    read_chk("hold c43", 3'd0, 32'd10, 32'd43);
    idle(19);
    read_chk("hold c63", 3'd0, 32'd10, 32'd43);
    read_chk("hold pcnt", 3'd5, 32'd0, 32'd0);

    // Atomic 64-bit read across a low-to-high carry.
    do_reset();
    write_reg(3'd1, 4'hF, 32'h0);
    write_reg(3'd0, 4'hF, 32'hFFFF_FFFE);
    idle(1);
    read_chk("atomic lo", 3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    read_chk("atomic hi", 3'd1, 32'h0000_0000, 32'h0000_0000);
    read_chk("atomic lo2", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    read_chk("atomic hi2", 3'd1, 32'h0000_0000, 32'h0000_0001);

    // Writes to mtime in tick cycles suppress the increment; pcnt keeps going.
    do_reset();
    idle(5);
    write_reg(3'd1, 4'hF, 32'h0);
    read_chk("tickwr hi", 3'd0, 32'd1, 32'd5);
    write_reg(3'd0, 4'hF, 32'h100);
    read_chk("tickwr lo", 3'd0, 32'h100, 32'h100);
    read_chk("tickwr pcnt", 3'd5, 32'd1, 32'd0);
    read_chk("tickwr after", 3'd0, 32'h100, 32'h102);

    // Interrupt rise at mtime==mtimecmp, fall after raising mtimecmp.
    do_reset();
    write_reg(3'd3, 4'hF, 32'h0);
    write_reg(3'd2, 4'hF, 32'd100);
    write_reg(3'd0, 4'hF, 32'h0);
    idle(100);
    check("irq before rise p1", 32'(irq1), 32'd0);
    idle(1);
    check("irq rise p1", 32'(irq1), 32'd1);
    check("irq stays low p4", 32'(irq4), 32'd0);
    write_reg(3'd3, 4'hF, 32'h1);
    check("irq one after cmp write", 32'(irq1), 32'd1);
    idle(1);
    check("irq fall p1", 32'(irq1), 32'd0);

    // Reset arriving while a read response is on the bus discards it.
    bus(1'b0, 1'b1, 3'd3, 4'h0, 32'h0);
    step();
    check("pre-reset rdv p1", 32'(rdv1), 32'd1);
    check("pre-reset data p1", rdata1, 32'h1);
    bus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("async rst rdv p4", 32'(rdv4), 32'd0);
    check("async rst rdv p1", 32'(rdv1), 32'd0);
    check("async rst data p1", rdata1, 32'h0);
    step();
    step();
    check("in rst rdv p1", 32'(rdv1), 32'd0);
    rst = 1'b0;
    idle(1);
    check("post rst rdv p1", 32'(rdv1), 32'd0);
    read_chk("post rst cmp hi", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
